// File: rtl/ospfb_capture_ctrl.sv
// ospfb_capture_ctrl: capture sequencer from the OSPFB output AXI-Stream into capture RAM.
// Arms on request, aligns to an FFT frame boundary with tlast, then writes
// FRAMES*FFT_LEN samples and reports a frame-aligned, complete capture on full.
// Optional feature macro: CAPTURE_TLAST_CHECK_EN enables tlast framing checks (err[1:0]).
module ospfb_capture_ctrl #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 64,
  parameter int FRAMES  = 32,
  localparam int SAMP   = FRAMES * FFT_LEN,
  localparam int AW     = $clog2(SAMP),
  localparam int FW     = $clog2(FRAMES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [2*WIDTH-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  input  logic               event_fft_overflow,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [2*WIDTH-1:0] ram_wdata,
  output logic               busy,
  output logic               full,
  output logic [2:0]         err,
  output logic [FW-1:0]      frame_cnt
);

  localparam int KW = $clog2(FFT_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(FFT_LEN - 1);
  localparam logic [AW-1:0] A_LAST = AW'(SAMP - 1);

  typedef enum logic [2:0] {IDLE, ALIGN, CAPTURE, DONE, ERROR} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [KW-1:0]      k_q, k_d;
  logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
  logic               frame_inc_q, frame_inc_d;
  logic [2:0]         err_q, err_d;
  logic               full_q, full_d;
  logic               full_set_q, full_set_d;
  logic               ram_we_q, ram_we_d;
  logic [AW-1:0]      ram_addr_q, ram_addr_d;
  logic [2*WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic               tready_q, tready_d;
  logic [2:0]         fault;
  logic               beat;
  logic               last_k;

  assign beat   = s_axis_tvalid & tready_q;
  assign last_k = (k_q == K_LAST);

  // Next-state, counters, write port and fault flags.
  // frame_cnt and full lag the final write by one cycle so RAM is complete before full rises.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    k_d         = k_q;
    frame_cnt_d = frame_cnt_q;
    frame_inc_d = 1'b0;
    err_d       = err_q;
    full_d      = full_q;
    full_set_d  = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tready_d    = 1'b1;
    fault       = 3'b000;

    if (frame_inc_q) frame_cnt_d = frame_cnt_q + FW'(1);
    if (full_set_q)  full_d      = 1'b1;

    case (state_q)
      IDLE, DONE, ERROR: begin
        // A restart clears everything, including any increment still in flight.
        if (arm) begin
          state_d     = ALIGN;
          addr_d      = '0;
          k_d         = '0;
          frame_cnt_d = '0;
          err_d       = 3'b000;
          full_d      = 1'b0;
        end
      end
      ALIGN: begin
        if (event_fft_overflow) begin
          err_d   = err_q | 3'b100;
          state_d = ERROR;
        end else if (beat && s_axis_tlast) begin
          // The frame-closing beat itself is dropped; the next beat is sample 0.
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        fault[2] = event_fft_overflow;
`ifdef CAPTURE_TLAST_CHECK_EN
        fault[1] = beat & last_k & ~s_axis_tlast;
        fault[0] = beat & ~last_k & s_axis_tlast;
`endif
        if (|fault) begin
          err_d   = err_q | fault;
          state_d = ERROR;
        end else if (beat) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = s_axis_tdata;
          k_d         = k_q + KW'(1);
          frame_inc_d = last_k;
          if (addr_q == A_LAST) begin
            state_d    = DONE;
            full_set_d = 1'b1;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; RAM contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      k_q         <= '0;
      frame_cnt_q <= '0;
      frame_inc_q <= 1'b0;
      err_q       <= 3'b000;
      full_q      <= 1'b0;
      full_set_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      k_q         <= k_d;
      frame_cnt_q <= frame_cnt_d;
      frame_inc_q <= frame_inc_d;
      err_q       <= err_d;
      full_q      <= full_d;
      full_set_q  <= full_set_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tready_q    <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign busy          = (state_q == ALIGN) || (state_q == CAPTURE);
  assign full          = full_q;
  assign err           = err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_ospfb_capture_ctrl.sv
// tb_ospfb_capture_ctrl: table of capture scenarios plus hand-written reset/restart
// sequences; every RAM write is checked against a queue of expected {addr, data}.
module tb_ospfb_capture_ctrl;
  localparam int AW      = 11;
  localparam int FW      = 6;
  localparam int FFT_LEN = 64;
  localparam int SAMP    = 2048;

  logic          clk = 1'b0;
  logic          rst, arm;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready, event_fft_overflow;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          busy, full;
  logic [2:0]    err;
  logic [FW-1:0] frame_cnt;

  ospfb_capture_ctrl dut (
    .clk(clk), .rst(rst), .arm(arm),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .event_fft_overflow(event_fft_overflow),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .full(full), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    int         gap;        // percent idle cycles between beats
    int         kind;       // 0 clean, 1 tlast missing, 2 overflow, 3 stray tlast
    int         fidx;       // beat index where the fault is injected
    int         exp_writes;
    logic [2:0] exp_err;
    logic       exp_full;
    int         exp_fc;
  } rec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  rec_t tbl[7];
  int   checks = 0;
  int   failures = 0;
  int   wr_count = 0;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ram_write_unexpected: got addr=%0d data=%h, required no write", ram_addr, ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (ram_addr !== mon_e.addr || ram_wdata !== mon_e.data) begin
          failures++;
          $display("FAIL ram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   ram_addr, ram_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish, required finish within 100000 cycles");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    s_axis_tvalid      = 1'b0;
    s_axis_tlast       = 1'b0;
    event_fft_overflow = 1'b0;
    arm                = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic ovf);
    s_axis_tvalid      = 1'b1;
    s_axis_tdata       = d;
    s_axis_tlast       = l;
    event_fft_overflow = ovf;
    tick();
    idle_in();
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = AW'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic run_rec(input int r);
    rec_t        t;
    int          stop;
    logic [31:0] d;
    logic        l, ovf;
    t    = tbl[r];
    stop = (t.exp_err != 3'b000) ? t.fidx : SAMP - 1;
    do_arm();
    chk($sformatf("rec%0d_busy_after_arm", r), busy, 1);
    wr_count = 0;
    send(32'hBAD0_0000 | 32'(r), 1'b0, 1'b0);  // ALIGN: discarded
    send(32'hBAD1_0000 | 32'(r), 1'b0, 1'b0);
    send(32'hA11C_0000 | 32'(r), 1'b1, 1'b0);  // frame boundary, not stored
    for (int i = 0; i <= stop; i++) begin
      while ($urandom_range(99) < t.gap) tick();
      d   = 32'(r * 65536 + i);
      l   = ((i % FFT_LEN) == FFT_LEN - 1);
      ovf = 1'b0;
      if (i == t.fidx) begin
        case (t.kind)
          1: l = 1'b0;
          2: ovf = 1'b1;
          3: l = 1'b1;
          default: ;
        endcase
      end
      if (i < t.exp_writes) expect_wr(i, d);
      send(d, l, ovf);
    end
    chk($sformatf("rec%0d_full_at_n1", r), full, 0);
    tick();
    chk($sformatf("rec%0d_full_at_n2", r), full, t.exp_full);
    chk($sformatf("rec%0d_frame_cnt", r), frame_cnt, t.exp_fc);
    chk($sformatf("rec%0d_busy_end", r), busy, 0);
    repeat (3) tick();
    chk($sformatf("rec%0d_err", r), err, t.exp_err);
    chk($sformatf("rec%0d_full_hold", r), full, t.exp_full);
    chk($sformatf("rec%0d_writes", r), wr_count, t.exp_writes);
    chk($sformatf("rec%0d_pending", r), exp_q.size(), 0);
    $display("rec %0d: kind=%0d gap=%0d writes=%0d err=%b full=%b frame_cnt=%0d",
             r, t.kind, t.gap, wr_count, err, full, frame_cnt);
  endtask

  initial begin
    tbl[0] = '{gap: 0,  kind: 0, fidx: -1,   exp_writes: 2048, exp_err: 3'b000, exp_full: 1'b1, exp_fc: 32};
    tbl[1] = '{gap: 30, kind: 0, fidx: -1,   exp_writes: 2048, exp_err: 3'b000, exp_full: 1'b1, exp_fc: 32};
`ifdef CAPTURE_TLAST_CHECK_EN
    tbl[2] = '{gap: 0,  kind: 1, fidx: 383,  exp_writes: 383,  exp_err: 3'b010, exp_full: 1'b0, exp_fc: 5};
    tbl[5] = '{gap: 0,  kind: 3, fidx: 10,   exp_writes: 10,   exp_err: 3'b001, exp_full: 1'b0, exp_fc: 0};
`else
    tbl[2] = '{gap: 0,  kind: 1, fidx: 383,  exp_writes: 2048, exp_err: 3'b000, exp_full: 1'b1, exp_fc: 32};
    tbl[5] = '{gap: 0,  kind: 3, fidx: 10,   exp_writes: 2048, exp_err: 3'b000, exp_full: 1'b1, exp_fc: 32};
`endif
    tbl[3] = '{gap: 10, kind: 0, fidx: -1,   exp_writes: 2048, exp_err: 3'b000, exp_full: 1'b1, exp_fc: 32};
    tbl[4] = '{gap: 0,  kind: 2, fidx: 2047, exp_writes: 2047, exp_err: 3'b100, exp_full: 1'b0, exp_fc: 31};
    tbl[6] = '{gap: 20, kind: 0, fidx: -1,   exp_writes: 2048, exp_err: 3'b000, exp_full: 1'b1, exp_fc: 32};

    // Reset values
    rst = 1'b1;
    idle_in();
    s_axis_tdata = 32'h5A5A_5A5A;
    repeat (3) tick();
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    tick();
    chk("tready_after_rst", s_axis_tready, 1);
    $display("reset: tready=%b busy=%b full=%b err=%b", s_axis_tready, busy, full, err);

    // Beats in IDLE are discarded
    send(32'h1111_1111, 1'b1, 1'b0);
    chk("idle_no_write", ram_we, 0);
    chk("idle_busy", busy, 0);

    // Reset at beat 1000, with an arm pulse mid-capture that must be ignored
    wr_count = 0;
    do_arm();
    send(32'hA11C_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      expect_wr(i, 32'h00F0_0000 | 32'(i));
      if (i == 500) arm = 1'b1;
      send(32'h00F0_0000 | 32'(i), ((i % FFT_LEN) == FFT_LEN - 1), 1'b0);
    end
    rst = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h00F0_03E8;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_ram_we", ram_we, 0);
    chk("midrst_tready", s_axis_tready, 0);
    rst = 1'b0;
    idle_in();
    tick();
    chk("midrst_tready_back", s_axis_tready, 1);
    repeat (2) tick();
    chk("midrst_writes", wr_count, 1000);
    chk("midrst_pending", exp_q.size(), 0);
    $display("mid-capture reset: writes=%0d busy=%b", wr_count, busy);

    // Restart after reset begins again at address 0
    wr_count = 0;
    do_arm();
    chk("restart_busy", busy, 1);
    send(32'h1234_5678, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_wr(i, 32'hC0DE_0000 | 32'(i));
      send(32'hC0DE_0000 | 32'(i), 1'b0, 1'b0);
    end
    repeat (3) tick();
    chk("restart_writes", wr_count, 3);
    chk("restart_pending", exp_q.size(), 0);
    $display("restart: writes=%0d busy=%b", wr_count, busy);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    for (int r = 0; r < 7; r++) run_rec(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
